// File: rtl/vector_alu_arbiter.sv
// vector_alu_arbiter
//   Shares one external 8-lane, 256-bit vector ALU between two requesters.
//   Arbitration is round-robin. The winner's operation and operands are
//   latched into issue registers and held on the ALU inputs. The ALU result
//   is captured after one execute cycle and returned on the winner's
//   response channel.
//
//   Ports
//     clk, rst_n                 clock, asynchronous active-low reset
//     reqN_valid / reqN_ready    request handshake, N = 0/1
//     reqN_op/_sub/_a/_b         operation, subtract-select, operands
//     rspN_valid / rspN_ready    response handshake
//     rsp_data                   registered result, shared by both channels
//     alu_op/_sub/_a/_b          issue registers driven to the ALU
//     alu_out                    ALU result (combinational from alu_*)
//     busy                       high outside IDLE
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | arbitrate; accept one request and latch it
//   EXEC  | issue registers drive the ALU; capture alu_out at cycle end
//   RESP  | present result to owner until owner's rsp_ready
module vector_alu_arbiter #(
  parameter int DATA_W = 256,
  parameter int OP_W   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OP_W-1:0]   req0_op,
  input  logic              req0_sub,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req1_op,
  input  logic              req1_sub,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [OP_W-1:0]   alu_op,
  output logic              alu_sub,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_out,
  output logic              busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_RESP} state_e;

  state_e              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic                owner_q, owner_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic                sub_q, sub_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                rsp0_valid_q, rsp0_valid_d;
  logic                rsp1_valid_q, rsp1_valid_d;
  logic                busy_q, busy_d;

  logic                winner;
  logic                idle_req;
  logic                owner_ready;

  // On a tie the port that did not win last time goes; otherwise the only
  // valid port wins (port 1 if req1_valid alone, port 0 otherwise).
  assign winner      = (req0_valid & req1_valid) ? ~last_grant_q : req1_valid;
  assign idle_req    = (state_q == ST_IDLE) & (req0_valid | req1_valid);
  assign owner_ready = owner_q ? rsp1_ready : rsp0_ready;

  // Gated by rst_n so no grant is visible while reset is held.
  assign req0_ready  = rst_n & idle_req & ~winner;
  assign req1_ready  = rst_n & idle_req &  winner;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    op_d         = op_q;
    sub_d        = sub_q;
    a_d          = a_q;
    b_d          = b_q;
    rsp_data_d   = rsp_data_q;
    rsp0_valid_d = rsp0_valid_q;
    rsp1_valid_d = rsp1_valid_q;
    busy_d       = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (idle_req) begin
          op_d         = winner ? req1_op  : req0_op;
          sub_d        = winner ? req1_sub : req0_sub;
          a_d          = winner ? req1_a   : req0_a;
          b_d          = winner ? req1_b   : req0_b;
          owner_d      = winner;
          last_grant_d = winner;
          state_d      = ST_EXEC;
          busy_d       = 1'b1;
        end
      end
      ST_EXEC: begin
        rsp_data_d   = alu_out;
        rsp0_valid_d = ~owner_q;
        rsp1_valid_d =  owner_q;
        state_d      = ST_RESP;
        busy_d       = 1'b1;
      end
      ST_RESP: begin
        if (owner_ready) begin
          rsp0_valid_d = 1'b0;
          rsp1_valid_d = 1'b0;
          state_d      = ST_IDLE;
          busy_d       = 1'b0;
        end
      end
      default: begin
        rsp0_valid_d = 1'b0;
        rsp1_valid_d = 1'b0;
        state_d      = ST_IDLE;
        busy_d       = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      op_q         <= '0;
      sub_q        <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      rsp_data_q   <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      op_q         <= op_d;
      sub_q        <= sub_d;
      a_q          <= a_d;
      b_q          <= b_d;
      rsp_data_q   <= rsp_data_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign alu_op     = op_q;
  assign alu_sub    = sub_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign rsp_data   = rsp_data_q;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_vector_alu_arbiter.sv
module tb_vector_alu_arbiter;
  localparam int DW = 256;
  localparam int OW = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] rv, rr;
  logic [OW-1:0] op0, op1;
  logic sub0, sub1;
  logic [DW-1:0] a0, b0, a1, b1;
  logic req0_ready, req1_ready, rsp0_valid, rsp1_valid, alu_sub, busy;
  logic [DW-1:0] rsp_data, alu_a, alu_b, alu_out;
  logic [OW-1:0] alu_op;

  int n_err = 0;
  int n_checks = 0;

  always #5 clk = ~clk;

  vector_alu_arbiter #(.DATA_W(DW), .OP_W(OW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(rv[0]), .req0_ready(req0_ready), .req0_op(op0), .req0_sub(sub0),
    .req0_a(a0), .req0_b(b0),
    .req1_valid(rv[1]), .req1_ready(req1_ready), .req1_op(op1), .req1_sub(sub1),
    .req1_a(a1), .req1_b(b1),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rr[0]),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rr[1]),
    .rsp_data(rsp_data), .alu_op(alu_op), .alu_sub(alu_sub),
    .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out), .busy(busy)
  );

  // Behavioural external ALU: per-lane add/sub, and, xor, or.
  function automatic logic [DW-1:0] alu_f(input logic [OW-1:0] op, input logic sub,
                                         input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW-1:0] r;
    logic [31:0] x, y;
    r = '0;
    for (int l = 0; l < 8; l++) begin
      x = a[l*32 +: 32];
      y = b[l*32 +: 32];
      case (op)
        3'd0:    r[l*32 +: 32] = sub ? x - y : x + y;
        3'd1:    r[l*32 +: 32] = x & y;
        3'd2:    r[l*32 +: 32] = x ^ y;
        default: r[l*32 +: 32] = x | y;
      endcase
    end
    return r;
  endfunction

  assign alu_out = alu_f(alu_op, alu_sub, alu_a, alu_b);

  function automatic logic [DW-1:0] rand256();
    logic [DW-1:0] r;
    r = '0;
    for (int l = 0; l < 8; l++) r[l*32 +: 32] = $urandom;
    return r;
  endfunction

  // Transaction-level reference: one op in flight, result due two cycles
  // after accept, then held until the owner takes it.
  logic m_busy, m_owner, m_last, m_sub;
  int   m_age;
  logic [OW-1:0] m_op;
  logic [DW-1:0] m_a, m_b, m_res, m_rsp_data;
  logic q_port[$];
  logic [DW-1:0] q_data[$];
  logic g_port[$];
  int   g_cyc[$];
  int   cyc = 0;
  int   n_rsp = 0;
  logic [1:0] dut_acc;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_owner = 1'b0; m_last = 1'b1; m_age = 0;
    m_op = '0; m_sub = 1'b0; m_a = '0; m_b = '0; m_res = '0; m_rsp_data = '0;
    q_port.delete(); q_data.delete();
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic tick();
    logic win;
    logic [1:0] exp_rdy, exp_rv;
    logic rvo, exp_port;
    #1;
    exp_rdy = 2'b00;
    win = 1'b0;
    if (!m_busy && (rv != 2'b00)) begin
      win = (rv == 2'b11) ? ~m_last : rv[1];
      exp_rdy[win] = 1'b1;
    end
    exp_rv = (m_busy && m_age >= 1) ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
    check("req_ready", {req1_ready, req0_ready}, exp_rdy);
    check("busy", busy, m_busy);
    check("rsp_valid", {rsp1_valid, rsp0_valid}, exp_rv);
    check("rsp_data", rsp_data, m_rsp_data);
    check("alu_a", alu_a, m_a);
    check("alu_b", alu_b, m_b);
    check("alu_op_sub", {alu_op, alu_sub}, {m_op, m_sub});
    dut_acc = {rv[1] & req1_ready, rv[0] & req0_ready};
    for (int p = 0; p < 2; p++) begin
      if (dut_acc[p]) begin g_port.push_back(p[0]); g_cyc.push_back(cyc); end
      rvo = (p == 1) ? rsp1_valid : rsp0_valid;
      if (rvo && rr[p]) begin
        n_rsp++;
        exp_port = (q_port.size() > 0) ? q_port[0] : ~p[0];
        check("sb_port", p[0], exp_port);
        if (q_data.size() > 0) check("sb_data", rsp_data, q_data[0]);
        if (q_port.size() > 0) begin void'(q_port.pop_front()); void'(q_data.pop_front()); end
      end
    end
    @(posedge clk);
    if (m_busy) begin
      if (m_age == 0) begin m_age = 1; m_rsp_data = m_res; end
      else if (rr[m_owner]) m_busy = 1'b0;
    end else if (rv != 2'b00) begin
      m_busy = 1'b1; m_age = 0; m_owner = win; m_last = win;
      m_op  = win ? op1 : op0;
      m_sub = win ? sub1 : sub0;
      m_a   = win ? a1 : a0;
      m_b   = win ? b1 : b0;
      m_res = alu_f(m_op, m_sub, m_a, m_b);
      q_port.push_back(win);
      q_data.push_back(m_res);
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain();
    rv = 2'b00; rr = 2'b11;
    for (int i = 0; i < 10 && m_busy; i++) tick();
    #1 check("drain_idle", busy, 1'b0);
  endtask

  task automatic rand_fields();
    op0 = 3'($urandom_range(0, 7)); op1 = 3'($urandom_range(0, 7));
    sub0 = 1'($urandom); sub1 = 1'($urandom);
    a0 = rand256(); b0 = rand256(); a1 = rand256(); b1 = rand256();
  endtask

  initial begin
    int base, max_wait;
    int wt[2];
    logic [DW-1:0] a_sent;
    rst_n = 1'b0; rv = 2'b11; rr = 2'b00;
    rand_fields();
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("rst_req_ready", {req1_ready, req0_ready}, 2'b00);
    check("rst_busy", busy, 1'b0);
    check("rst_rsp_valid", {rsp1_valid, rsp0_valid}, 2'b00);
    check("rst_rsp_data", rsp_data, '0);
    check("rst_alu_a", alu_a, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Tie after reset: 0,1,0,1 spaced 3 cycles.
    rv = 2'b11; rr = 2'b11;
    base = g_port.size();
    repeat (12) tick();
    check("tie_count_ge4", (g_port.size() - base) >= 4, 1'b1);
    for (int i = 0; i < 4 && base + i < g_port.size(); i++) begin
      check("tie_order", g_port[base+i], i[0]);
      if (i > 0) check("tie_spacing", g_cyc[base+i] - g_cyc[base+i-1], 3);
    end
    drain();

    // Single op on port 0.
    rv = 2'b01; rr = 2'b01;
    op0 = 3'b010; sub0 = 1'b0;
    a0 = {8{32'h0000_00FF}}; b0 = {8{32'h0000_0F0F}};
    a_sent = a0;
    tick();
    rv = 2'b00;
    #1;
    check("single_alu_op", alu_op, 3'b010);
    check("single_alu_a", alu_a, a_sent);
    tick();
    #1;
    check("single_rsp0_valid", rsp0_valid, 1'b1);
    check("single_rsp1_valid", rsp1_valid, 1'b0);
    check("single_rsp_data", rsp_data, {8{32'h0000_0FF0}});
    tick();
    #1 check("single_idle_busy", busy, 1'b0);
    drain();

    // Backpressure on port 1 while port 0 waits.
    rand_fields();
    rv = 2'b10; rr = 2'b00;
    tick();
    rv = 2'b01;
    tick();
    repeat (5) tick();
    rr = 2'b10;
    tick();
    #1;
    check("bp_idle_busy", busy, 1'b0);
    check("bp_idle_req0_ready", req0_ready, 1'b1);
    tick();
    drain();

    // Operand isolation.
    rv = 2'b01; rr = 2'b01;
    op0 = 3'b010; sub0 = 1'b0;
    a0 = {8{32'h1234_5678}}; b0 = {8{32'h0F0F_0F0F}};
    tick();
    rv = 2'b00;
    a0 = '1;
    tick();
    #1 check("iso_rsp_data", rsp_data, {8{32'h1D3B_5977}});
    drain();

    // Reset during EXEC.
    rand_fields();
    rv = 2'b01; rr = 2'b11;
    tick();
    rv = 2'b11;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_req_ready", {req1_ready, req0_ready}, 2'b00);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_rsp_valid", {rsp1_valid, rsp0_valid}, 2'b00);
    check("mid_rst_rsp_data", rsp_data, '0);
    check("mid_rst_alu", {alu_op, alu_sub, alu_a}, '0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("mid_rst_tie_port0", dut_acc, 2'b01);
    drain();

    // Soak, part 1: fully random valid/ready.
    for (int i = 0; i < 5000; i++) begin
      rv = 2'($urandom); rr = 2'($urandom);
      rand_fields();
      tick();
    end
    drain();

    // Soak, part 2: requests held until granted, response-ready held high.
    rr = 2'b11; rv = 2'b00;
    wt[0] = 0; wt[1] = 0; max_wait = 0;
    for (int i = 0; i < 5000; i++) begin
      for (int p = 0; p < 2; p++)
        if (!rv[p] && $urandom_range(0, 1) == 1) begin rv[p] = 1'b1; wt[p] = 0; end
      rand_fields();
      tick();
      for (int p = 0; p < 2; p++) begin
        if (rv[p] && dut_acc[p]) rv[p] = 1'b0;
        else if (rv[p]) begin
          wt[p]++;
          if (wt[p] > max_wait) max_wait = wt[p];
        end
      end
    end
    drain();
    check("soak_max_wait_le6", max_wait <= 6, 1'b1);
    check("soak_queue_empty", q_port.size(), 0);
    check("soak_responses_seen", n_rsp > 1000, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
